// File: rtl/cti_resolve_queue.sv
// CTI tracking queue: allocates IDs at dispatch, records control-pipe resolutions,
// pulses a redirect on mispredict and drains committed CTIs to the predictor update port.
module cti_resolve_queue #(
  parameter int DEPTH           = 16,
  parameter int SIZE_CTI_LOG    = 4,
  parameter int SIZE_PC         = 32,
  parameter int BRANCH_TYPE_LOG = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       alloc_i,
  input  logic [SIZE_PC-1:0]         allocPredNPC_i,
  input  logic                       allocPredDir_i,
  output logic [SIZE_CTI_LOG-1:0]    ctiID_o,
  output logic                       full_o,
  input  logic                       exeCtrlValid_i,
  input  logic [SIZE_PC-1:0]         exeCtrlPC_i,
  input  logic [BRANCH_TYPE_LOG-1:0] exeCtrlType_i,
  input  logic [SIZE_PC-1:0]         exeCtrlNPC_i,
  input  logic                       exeCtrlDir_i,
  input  logic [SIZE_CTI_LOG-1:0]    exeCtiID_i,
  input  logic                       commitCti_i,
  output logic                       mispredict_o,
  output logic [SIZE_PC-1:0]         redirectPC_o,
  output logic [SIZE_CTI_LOG-1:0]    mispredictID_o,
  output logic                       updValid_o,
  output logic [SIZE_PC-1:0]         updPC_o,
  output logic [BRANCH_TYPE_LOG-1:0] updType_o,
  output logic [SIZE_PC-1:0]         updNPC_o,
  output logic                       updDir_o,
  output logic                       updMispred_o,
  input  logic                       updReady_i,
  output logic                       protoErr_o
);

  localparam int PW = SIZE_CTI_LOG + 1;

  logic [PW-1:0]              head, tail, commitCnt, count, effCnt;
  logic [SIZE_CTI_LOG-1:0]    headIdx, tailIdx, off;
  logic [DEPTH-1:0]           valid, resolved, killMask;
  logic [DEPTH-1:0]           predDir, actDir;
  logic [SIZE_PC-1:0]         predNPC [DEPTH];
  logic [SIZE_PC-1:0]         ctiPC   [DEPTH];
  logic [SIZE_PC-1:0]         actNPC  [DEPTH];
  logic [BRANCH_TYPE_LOG-1:0] ctiType [DEPTH];

  logic allocDo, commitOk, drainGo, resHit, resOk, resDo, resMiss, errNow;
  logic unusedPredDir;

  assign headIdx = head[SIZE_CTI_LOG-1:0];
  assign tailIdx = tail[SIZE_CTI_LOG-1:0];
  assign count   = tail - head;
  assign full_o  = (count == PW'(DEPTH));
  assign ctiID_o = tailIdx;

  assign allocDo  = alloc_i && !full_o && !flush_i;
  assign commitOk = commitCti_i && (commitCnt != count);
  // Same-cycle commit counts toward drain eligibility, giving one-cycle commit-to-update latency.
  assign effCnt   = commitCnt + PW'(commitOk);
  assign drainGo  = (effCnt != '0) && resolved[headIdx] && (!updValid_o || updReady_i);
  assign resHit   = valid[exeCtiID_i] && !resolved[exeCtiID_i];
  assign resOk    = exeCtrlValid_i && resHit;
  assign resDo    = resOk && !flush_i;
  assign resMiss  = (exeCtrlNPC_i != predNPC[exeCtiID_i]);

  assign errNow = (alloc_i && full_o) ||
                  (exeCtrlValid_i && !resHit) ||
                  (commitCti_i && !commitOk) ||
                  ((effCnt != '0) && !resolved[headIdx]);

  // Predicted direction is kept per entry for observability; resolution compares NPC only.
  assign unusedPredDir = ^predDir;

  // Entries at or beyond head+effCnt (ring distance from head) are speculative and die on flush.
  always_comb begin
    killMask = '0;
    off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off         = SIZE_CTI_LOG'(i) - headIdx;
      killMask[i] = flush_i && ({1'b0, off} >= effCnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      commitCnt <= '0;
      valid     <= '0;
      resolved  <= '0;
    end else begin
      head      <= head + PW'(drainGo);
      commitCnt <= effCnt - PW'(drainGo);
      tail      <= flush_i ? (head + effCnt) : (tail + PW'(allocDo));
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (allocDo && (tailIdx == SIZE_CTI_LOG'(i))) begin
          valid[i]    <= 1'b1;
          resolved[i] <= 1'b0;
        end
        if (resDo && (exeCtiID_i == SIZE_CTI_LOG'(i)))
          resolved[i] <= 1'b1;
        if ((drainGo && (headIdx == SIZE_CTI_LOG'(i))) || killMask[i]) begin
          valid[i]    <= 1'b0;
          resolved[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (allocDo) begin
      predNPC[tailIdx] <= allocPredNPC_i;
      predDir[tailIdx] <= allocPredDir_i;
    end
    if (resDo) begin
      ctiPC[exeCtiID_i]   <= exeCtrlPC_i;
      ctiType[exeCtiID_i] <= exeCtrlType_i;
      actNPC[exeCtiID_i]  <= exeCtrlNPC_i;
      actDir[exeCtiID_i]  <= exeCtrlDir_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict_o   <= 1'b0;
      redirectPC_o   <= '0;
      mispredictID_o <= '0;
      protoErr_o     <= 1'b0;
    end else begin
      mispredict_o <= resDo && resMiss;
      if (resDo && resMiss) begin
        redirectPC_o   <= exeCtrlNPC_i;
        mispredictID_o <= exeCtiID_i;
      end
      if (errNow)
        protoErr_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      updValid_o   <= 1'b0;
      updPC_o      <= '0;
      updType_o    <= '0;
      updNPC_o     <= '0;
      updDir_o     <= 1'b0;
      updMispred_o <= 1'b0;
    end else if (drainGo) begin
      updValid_o   <= 1'b1;
      updPC_o      <= ctiPC[headIdx];
      updType_o    <= ctiType[headIdx];
      updNPC_o     <= actNPC[headIdx];
      updDir_o     <= actDir[headIdx];
      updMispred_o <= (actNPC[headIdx] != predNPC[headIdx]);
    end else if (updReady_i) begin
      updValid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cti_resolve_queue.sv
// Directed bench for cti_resolve_queue with hand-computed expectations.
module tb_cti_resolve_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i, alloc_i, allocPredDir_i;
  logic [31:0] allocPredNPC_i;
  logic [3:0]  ctiID_o;
  logic        full_o;
  logic        exeCtrlValid_i, exeCtrlDir_i;
  logic [31:0] exeCtrlPC_i, exeCtrlNPC_i;
  logic [1:0]  exeCtrlType_i;
  logic [3:0]  exeCtiID_i;
  logic        commitCti_i;
  logic        mispredict_o;
  logic [31:0] redirectPC_o;
  logic [3:0]  mispredictID_o;
  logic        updValid_o, updDir_o, updMispred_o, updReady_i, protoErr_o;
  logic [31:0] updPC_o, updNPC_o;
  logic [1:0]  updType_o;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  cti_resolve_queue #(.DEPTH(16), .SIZE_CTI_LOG(4), .SIZE_PC(32), .BRANCH_TYPE_LOG(2)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .alloc_i(alloc_i),
    .allocPredNPC_i(allocPredNPC_i), .allocPredDir_i(allocPredDir_i),
    .ctiID_o(ctiID_o), .full_o(full_o),
    .exeCtrlValid_i(exeCtrlValid_i), .exeCtrlPC_i(exeCtrlPC_i), .exeCtrlType_i(exeCtrlType_i),
    .exeCtrlNPC_i(exeCtrlNPC_i), .exeCtrlDir_i(exeCtrlDir_i), .exeCtiID_i(exeCtiID_i),
    .commitCti_i(commitCti_i), .mispredict_o(mispredict_o), .redirectPC_o(redirectPC_o),
    .mispredictID_o(mispredictID_o), .updValid_o(updValid_o), .updPC_o(updPC_o),
    .updType_o(updType_o), .updNPC_o(updNPC_o), .updDir_o(updDir_o),
    .updMispred_o(updMispred_o), .updReady_i(updReady_i), .protoErr_o(protoErr_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [3:0] id, input logic [31:0] pc, input logic [1:0] ty,
                         input logic [31:0] npc, input logic dir);
    exeCtrlValid_i = 1'b1;
    exeCtiID_i     = id;
    exeCtrlPC_i    = pc;
    exeCtrlType_i  = ty;
    exeCtrlNPC_i   = npc;
    exeCtrlDir_i   = dir;
  endtask

  initial begin
    reset = 1'b0; flush_i = 0; alloc_i = 0; allocPredNPC_i = '0; allocPredDir_i = 0;
    exeCtrlValid_i = 0; exeCtrlPC_i = '0; exeCtrlType_i = '0; exeCtrlNPC_i = '0;
    exeCtrlDir_i = 0; exeCtiID_i = '0; commitCti_i = 0; updReady_i = 0;
    tick(); tick(); tick();
    chk("rst_mispredict", mispredict_o, 0);
    chk("rst_updValid", updValid_o, 0);
    chk("rst_protoErr", protoErr_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_ctiID", ctiID_o, 0);
    chk("rst_redirect", redirectPC_o, 0);
    reset = 1'b1;
    tick();

    // Allocate three CTIs
    alloc_i = 1; allocPredDir_i = 1;
    allocPredNPC_i = 32'h104; chk("alloc0_id", ctiID_o, 0); tick();
    allocPredNPC_i = 32'h208; chk("alloc1_id", ctiID_o, 1); tick();
    allocPredNPC_i = 32'h30C; chk("alloc2_id", ctiID_o, 2); chk("alloc2_full", full_o, 0); tick();
    alloc_i = 0;

    // Resolve ID1 wrong, then ID0 right
    resolve(4'd1, 32'h204, 2'd1, 32'h400, 1'b1);
    tick();
    chk("mp_pulse", mispredict_o, 1);
    chk("mp_redirect", redirectPC_o, 32'h400);
    chk("mp_id", mispredictID_o, 1);
    resolve(4'd0, 32'h100, 2'd0, 32'h104, 1'b1);
    tick();
    chk("mp_one_cycle", mispredict_o, 0);
    exeCtrlValid_i = 0;
    tick();
    chk("mp_none_correct", mispredict_o, 0);

    // Commit two with update port stalled
    commitCti_i = 1; updReady_i = 0;
    tick();
    chk("upd_valid_1cyc", updValid_o, 1);
    chk("upd_pc0", updPC_o, 32'h100);
    chk("upd_mispred0", updMispred_o, 0);
    tick();
    commitCti_i = 0;
    for (int c = 0; c < 3; c++) begin
      chk("upd_hold_valid", updValid_o, 1);
      chk("upd_hold_pc", updPC_o, 32'h100);
      if (c < 2) tick();
    end
    updReady_i = 1;
    tick();
    chk("upd1_valid", updValid_o, 1);
    chk("upd1_pc", updPC_o, 32'h204);
    chk("upd1_npc", updNPC_o, 32'h400);
    chk("upd1_type", updType_o, 1);
    chk("upd1_dir", updDir_o, 1);
    chk("upd1_mispred", updMispred_o, 1);
    tick();
    chk("upd_empty", updValid_o, 0);
    chk("protoErr_clean", protoErr_o, 0);

    // Fill: head=2, tail=3, 15 more allocations wrap the tail
    alloc_i = 1;
    for (int i = 0; i < 15; i++) begin
      allocPredNPC_i = 32'h3000 + 32'(i);
      chk("fill_id", ctiID_o, 64'((3 + i) % 16));
      tick();
    end
    chk("fill_full", full_o, 1);
    chk("fill_id_wrap", ctiID_o, 2);
    chk("fill_noerr", protoErr_o, 0);
    tick();
    alloc_i = 0;
    chk("overflow_err", protoErr_o, 1);
    chk("overflow_full", full_o, 1);
    chk("overflow_id", ctiID_o, 2);
    resolve(4'd2, 32'h308, 2'd3, 32'h30C, 1'b0);
    tick();
    exeCtrlValid_i = 0;
    commitCti_i = 1;
    tick();
    commitCti_i = 0;
    chk("drain_notfull", full_o, 0);
    chk("drain_upd_pc", updPC_o, 32'h308);
    chk("drain_upd_mispred", updMispred_o, 0);
    chk("reuse_id", ctiID_o, 2);
    alloc_i = 1; allocPredNPC_i = 32'h4000;
    tick();
    alloc_i = 0;
    chk("refull", full_o, 1);
    tick();

    // Flush with committed-but-unresolved head
    reset = 0;
    tick();
    chk("rst2_protoErr", protoErr_o, 0);
    reset = 1;
    alloc_i = 1;
    for (int i = 0; i < 4; i++) begin
      allocPredNPC_i = 32'h1000 + 32'(16 * i);
      tick();
    end
    alloc_i = 0;
    commitCti_i = 1;
    tick();
    commitCti_i = 0;
    chk("flush_pre_id", ctiID_o, 4);
    flush_i = 1; alloc_i = 1; allocPredNPC_i = 32'h9999;
    resolve(4'd2, 32'h1018, 2'd1, 32'h7777, 1'b1);
    tick();
    flush_i = 0; alloc_i = 0; exeCtrlValid_i = 0;
    chk("flush_no_mp", mispredict_o, 0);
    chk("flush_tail_id", ctiID_o, 1);
    chk("flush_full", full_o, 0);
    chk("unres_head_err", protoErr_o, 1);
    tick();
    chk("flush_no_mp2", mispredict_o, 0);
    alloc_i = 1; allocPredNPC_i = 32'h2000;
    chk("post_flush_id", ctiID_o, 1);
    tick();
    alloc_i = 0;
    chk("post_flush_next", ctiID_o, 2);
    updReady_i = 0;
    resolve(4'd0, 32'hFF0, 2'd2, 32'h1000, 1'b0);
    tick();
    exeCtrlValid_i = 0;
    chk("head_res_no_mp", mispredict_o, 0);
    tick();
    chk("head_drain_valid", updValid_o, 1);
    chk("head_drain_pc", updPC_o, 32'hFF0);
    chk("head_drain_type", updType_o, 2);
    chk("head_drain_npc", updNPC_o, 32'h1000);

    // Asynchronous reset mid-drain
    reset = 0;
    #2;
    chk("arst_updValid", updValid_o, 0);
    chk("arst_updPC", updPC_o, 0);
    chk("arst_updNPC", updNPC_o, 0);
    chk("arst_protoErr", protoErr_o, 0);
    chk("arst_ctiID", ctiID_o, 0);
    chk("arst_mispredict", mispredict_o, 0);
    tick();
    reset = 1;
    alloc_i = 1; allocPredNPC_i = 32'h5000;
    chk("arst_alloc_id", ctiID_o, 0);
    tick();
    alloc_i = 0;
    chk("arst_alloc_next", ctiID_o, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/cti_resolve_queue.md
# cti_resolve_queue

Control-transfer-instruction (CTI) tracking queue at the receiving end of the control execution pipe's resolution interface. Dispatch allocates one entry per branch/jump carrying the predicted outcome, and the entry's index is the CTI ID that travels down the pipe. The control pipe's writeback returns the actual outcome tagged with that ID; the queue raises a one-cycle mispredict redirect. In-order commit drains resolved entries to the branch predictor and BTB through a valid/ready update port.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two; equals 2^SIZE_CTI_LOG
- SIZE_CTI_LOG, 4, CTI ID width
- SIZE_PC, 32, PC width
- BRANCH_TYPE_LOG, 2, branch type encoding width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- flush_i  in  1  recovery or exception flush
- alloc_i  in  1  dispatch allocates one CTI entry
- allocPredNPC_i  in  SIZE_PC  predicted next PC
- allocPredDir_i  in  1  predicted direction
- ctiID_o  out  SIZE_CTI_LOG  ID assigned to the current alloc_i; equals tail[SIZE_CTI_LOG-1:0]; combinational
- full_o  out  1  count==DEPTH
- exeCtrlValid_i  in  1  resolution valid from control pipe writeback
- exeCtrlPC_i  in  SIZE_PC  CTI PC
- exeCtrlType_i  in  BRANCH_TYPE_LOG  CTI type
- exeCtrlNPC_i  in  SIZE_PC  actual next PC
- exeCtrlDir_i  in  1  actual direction
- exeCtiID_i  in  SIZE_CTI_LOG  entry being resolved
- commitCti_i  in  1  active list retires one CTI this cycle
- mispredict_o  out  1  one-cycle redirect pulse
- redirectPC_o  out  SIZE_PC  correct fetch PC
- mispredictID_o  out  SIZE_CTI_LOG  ID of the mispredicted CTI
- updValid_o, updPC_o, updType_o, updNPC_o, updDir_o, updMispred_o  out  1/SIZE_PC/BRANCH_TYPE_LOG/SIZE_PC/1/1  predictor update
- updReady_i  in  1  predictor accepts the update
- protoErr_o  out  1  sticky protocol-violation flag

## Operation
Per-entry state:
- valid, resolved, predNPC, predDir, PC, type, actNPC, actDir

Pointers and counters:
- head and tail pointers, SIZE_CTI_LOG+1 bits each, with a wrap bit
- count = tail - head
- commitCnt is the number of committed but undrained CTIs; range 0..DEPTH

Allocate:
- Condition: alloc_i && !full_o.
- Write the entry at tail: valid=1, resolved=0, and the predicted fields. Increment tail.
- alloc_i while full: ignored and sets protoErr_o.

Resolve:
- Condition: exeCtrlValid_i with entry[exeCtiID_i].valid.
- Store PC, type, actNPC and actDir; set resolved.
- Mispredict when exeCtrlNPC_i != predNPC. The next cycle drives mispredict_o=1, redirectPC_o=exeCtrlNPC_i and mispredictID_o=exeCtiID_i.
- Resolving an invalid or already-resolved entry: ignored and sets protoErr_o.

Commit:
- commitCti_i increments commitCnt.
- commitCti_i when commitCnt==count sets protoErr_o and is otherwise ignored.

Drain:
- Condition: commitCnt>0 && entry[head].resolved && (!updValid_o || updReady_i).
- Load the update register from the head entry; updMispred_o = (actNPC != predNPC).
- Clear entry[head].valid; increment head; decrement commitCnt.
- Committed but unresolved head: hold, and set protoErr_o.

Flush:
- Invalidate every entry beyond head+commitCnt.
- Set tail = head + commitCnt; take commitCnt including the same-cycle commitCti_i.
- Drops the same-cycle alloc and resolve, and suppresses a mispredict_o pulse that would follow from a same-cycle resolve.
- Update register and drain are unaffected.

Same-cycle combinations:
- Alloc and drain in the same cycle are both legal.
- Commit and drain in the same cycle: commitCnt is unchanged.
- Several events may act on the same entry in one cycle; each updates only its own fields.

Reset, while asserted and asynchronously:
- head, tail, commitCnt = 0; all valid and resolved bits = 0.
- mispredict_o, updValid_o, protoErr_o = 0.
- redirectPC_o, mispredictID_o and all upd* data outputs = 0.
- Takes effect mid-operation with no residual state.

## Timing
- ctiID_o and full_o are valid in the cycle of alloc_i; full_o is derived from registered pointers.
- Resolve to mispredict_o: 1 cycle. The pulse lasts exactly 1 cycle, with one pulse per resolving CTI.
- Commit to updValid_o: 1 cycle minimum when the head is already resolved.
- Back-to-back drains: 1 per cycle while updReady_i=1.
- updValid_o and its data stay stable until updReady_i=1; the handshake completes in the cycle both are high.
- A freed slot is reusable in the cycle after the drain.

## Test plan
- Reset, alloc 3 entries with predNPC 0x104, 0x208, 0x30C → ctiID_o 0,1,2; full_o=0.
- Resolve ID1 with NPC 0x400 (pred 0x208) → mispredict_o=1 for one cycle with redirectPC_o=0x400, mispredictID_o=1; resolve ID0 correctly → no pulse.
- Commit 2 with updReady_i=0 for 3 cycles → updValid_o held with updPC_o of ID0; raise updReady_i → ID0 then ID1 (updMispred_o=1) on consecutive cycles.
- Fill 16 entries → full_o=1; a 17th alloc is ignored and protoErr_o=1. Drain one → the next alloc gets ID 0 (wrap).
- With 4 allocated and 1 committed but unresolved, flush_i plus a same-cycle resolve of ID2 → tail=head+1, no mispredict_o; the next alloc gets ID head+1.
- Assert reset mid-drain with updValid_o=1 → all outputs 0 immediately and the next alloc gets ID 0.
